// File: rtl/mem_cache.sv
// mem_cache: direct-mapped, write-through, no-write-allocate cache that sits
// between a CPU request port and a slower backing memory.
//
// The CPU word address is split as {tag, index, offset}. Read hits answer in
// the cycle after the request is seen. Read misses fetch the whole line one
// word at a time, with a single idle cycle after every memory beat. Writes
// always go straight to memory and update the cached copy only on a hit.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   cpu_macc/cpu_rd   CPU request valid and direction (1 = read)
//   cpu_addr/cpu_din  CPU word address and write data (held until complete)
//   cpu_dout          read data, valid while cpu_complete is high
//   cpu_complete      one-cycle done pulse to the CPU
//   mem_macc/mem_rd   backing-memory request valid and direction
//   mem_addr/mem_din  backing-memory address and write data
//   mem_dout          backing-memory read data
//   mem_complete      backing-memory done pulse
//   flush             single-cycle invalidate-all request
//   hit_cnt/miss_cnt  saturating read hit/miss statistics

module mem_cache #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_macc,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_complete,
  output logic              mem_macc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_complete,
  input  logic              flush,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  // Tag width must be at least one bit for the address split to make sense.
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORDS  = 1 << OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FILL_GAP,
    WRITE,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_d;
  logic                flush_pend_q, flush_pend_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic [DATA_W-1:0]   data_mem [LINES*WORDS];
  logic [TAG_W-1:0]    tag_mem  [LINES];

  logic                        data_we;
  logic [INDEX_W+OFFSET_W-1:0] data_waddr;
  logic [DATA_W-1:0]           data_wdata;
  logic                        tag_we;
  logic [INDEX_W-1:0]          tag_waddr;
  logic [TAG_W-1:0]            tag_wdata;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_off;
  logic                req_hit;
  logic [INDEX_W-1:0]  fill_index;
  logic [TAG_W-1:0]    fill_tag;

  // The CPU holds its address stable for the whole transaction, so the
  // decoded request fields stay usable in every state.
  assign req_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_index  = cpu_addr[OFFSET_W +: INDEX_W];
  assign req_off    = cpu_addr[OFFSET_W-1:0];
  assign req_hit    = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign fill_index = line_q[INDEX_W-1:0];
  assign fill_tag   = line_q[LINE_W-1 -: TAG_W];

  assign cpu_dout = cpu_dout_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Controller: next state, register updates and all handshake outputs.
  // Memory-side outputs are decoded from the state alone so reset drives
  // them to their idle values without waiting for a clock edge.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    cpu_dout_d   = cpu_dout_q;
    flush_pend_d = flush_pend_q | flush;
    valid_d      = valid_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    data_we      = 1'b0;
    data_waddr   = {fill_index, beat_q};
    data_wdata   = mem_dout;
    tag_we       = 1'b0;
    tag_waddr    = fill_index;
    tag_wdata    = fill_tag;
    mem_macc     = 1'b0;
    mem_rd       = 1'b1;
    mem_addr     = '0;
    mem_din      = '0;
    cpu_complete = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending or same-cycle flush wins over any CPU request.
        if (flush_pend_q || flush) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_macc) begin
          if (cpu_rd) begin
            if (req_hit) begin
              cpu_dout_d = data_mem[{req_index, req_off}];
              state_d    = RESP;
              if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
              // The victim line is dropped up front so a refill that is cut
              // short by reset can never look valid.
              valid_d[req_index] = 1'b0;
              line_d             = cpu_addr[ADDR_W-1:OFFSET_W];
              beat_d             = '0;
              state_d            = FILL;
              if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
          end else begin
            state_d = WRITE;
          end
        end
      end

      FILL: begin
        mem_macc = 1'b1;
        mem_addr = {line_q, beat_q};
        if (mem_complete) begin
          data_we = 1'b1;
          if (beat_q == req_off) cpu_dout_d = mem_dout;
          state_d = FILL_GAP;
        end
      end

      FILL_GAP: begin
        if (&beat_q) begin
          valid_d[fill_index] = 1'b1;
          tag_we              = 1'b1;
          state_d             = RESP;
        end else begin
          beat_d  = beat_q + OFFSET_W'(1);
          state_d = FILL;
        end
      end

      WRITE: begin
        mem_macc = 1'b1;
        mem_rd   = 1'b0;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        if (mem_complete) begin
          if (req_hit) begin
            data_we    = 1'b1;
            data_waddr = {req_index, req_off};
            data_wdata = cpu_din;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        cpu_complete = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control, valid bits and statistics; all cleared by the async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      cpu_dout_q   <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      cpu_dout_q   <= cpu_dout_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Data and tag storage need no reset: nothing is read unless valid is set.
  always_ff @(posedge clock) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we) tag_mem[tag_waddr] <= tag_wdata;
  end

endmodule
